// File: rtl/irq_pending_if.sv
// Request/acknowledge bundle between the raw interrupt lines, the pending
// tracker and its consumer (priority encoder plus service handshake).
interface irq_pending_if;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       ack;
    logic [1:0] ack_id;
    logic       eoi;
    logic       clr_ovf;
    logic [3:0] pend;
    logic       irq_out;
    logic       in_svc;
    logic [1:0] svc_id;
    logic [3:0] ovf;

    modport master (
        output irq, mask, ack, ack_id, eoi, clr_ovf,
        input  pend, irq_out, in_svc, svc_id, ovf
    );

    modport slave (
        input  irq, mask, ack, ack_id, eoi, clr_ovf,
        output pend, irq_out, in_svc, svc_id, ovf
    );
endinterface

// File: rtl/irq_pending.sv
// Four-line interrupt pending tracker: synchronises raw lines, latches rising
// edges as pending bits, flags overflows and runs the ack/eoi service handshake.
module irq_pending #(
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst_n,
    irq_pending_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACTIVE, SERVICE} state_t;

    state_t     state_reg, state_next;
    logic [3:0] sync_last;
    logic [3:0] prev_reg;
    logic [3:0] edge_vec;
    logic [3:0] pending_reg, pending_next;
    logic [3:0] ovf_reg, ovf_next;
    logic [3:0] ack_clr;
    logic [1:0] svc_id_reg, svc_id_next;
    logic       accept;
    logic [SYNC_STAGES:0] ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) chain_reg <= '0;
                else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], bus.irq[gi]};
            end
            assign sync_last[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    // The chain and prev fill one cycle apart after reset; hold edge detection
    // off until both have settled so lines already high never look like edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_reg <= '0;
        else        ready_reg <= {ready_reg[SYNC_STAGES-1:0], 1'b1};
    end

    assign edge_vec = sync_last & ~prev_reg & {4{ready_reg[SYNC_STAGES]}};
    assign bus.pend = pending_reg & ~bus.mask;
    assign accept   = (state_reg == ACTIVE) && bus.ack && bus.pend[bus.ack_id];
    assign ack_clr  = accept ? (4'b0001 << bus.ack_id) : 4'b0000;

    always_comb begin
        // A new edge on the bit being acknowledged re-arms it and is not an overflow.
        pending_next = (pending_reg & ~ack_clr) | edge_vec;
        ovf_next     = (ovf_reg & ~{4{bus.clr_ovf}}) | (edge_vec & pending_reg & ~ack_clr);
        svc_id_next  = accept ? bus.ack_id : svc_id_reg;
        state_next   = state_reg;
        case (state_reg)
            IDLE:    if (|bus.pend) state_next = ACTIVE;
            ACTIVE: begin
                if (accept)          state_next = SERVICE;
                else if (~|bus.pend) state_next = IDLE;
            end
            SERVICE: if (bus.eoi) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            prev_reg    <= '0;
            pending_reg <= '0;
            ovf_reg     <= '0;
            svc_id_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            prev_reg    <= sync_last;
            pending_reg <= pending_next;
            ovf_reg     <= ovf_next;
            svc_id_reg  <= svc_id_next;
        end
    end

    assign bus.irq_out = (state_reg == ACTIVE);
    assign bus.in_svc  = (state_reg == SERVICE);
    assign bus.svc_id  = svc_id_reg;
    assign bus.ovf     = ovf_reg;
endmodule

// File: tb/tb_irq_pending.sv
// Directed bench for irq_pending: latency, handshake, bad acks, overflow,
// masking and asynchronous reset, with hand-computed expectations.
module tb_irq_pending;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    irq_pending_if bus();

    irq_pending #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack(input logic [1:0] id);
        bus.ack    = 1'b1;
        bus.ack_id = id;
        step(1);
        bus.ack    = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        step(1);
        bus.eoi = 1'b0;
    endtask

    task automatic pulse_irq(input int line);
        bus.irq[line] = 1'b1;
        step(2);
        bus.irq[line] = 1'b0;
        step(2);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.irq = 4'h0; bus.mask = 4'h0; bus.ack = 1'b0; bus.ack_id = 2'd0;
        bus.eoi = 1'b0; bus.clr_ovf = 1'b0;

        // Reset state
        step(1);
        check_val("rst_pend",    {4'h0, bus.pend}, 8'h00);
        check_val("rst_irq_out", {7'h0, bus.irq_out}, 8'h00);
        check_val("rst_in_svc",  {7'h0, bus.in_svc}, 8'h00);
        check_val("rst_svc_id",  {6'h0, bus.svc_id}, 8'h00);
        check_val("rst_ovf",     {4'h0, bus.ovf}, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(4);

        // Latency: pend two edges after first sampling, irq_out one later
        bus.irq = 4'b0001;
        step(1);
        check_val("lat_pend_k",   {4'h0, bus.pend}, 8'h00);
        step(1);
        check_val("lat_pend_k1",  {4'h0, bus.pend}, 8'h00);
        step(1);
        check_val("lat_pend_k2",  {4'h0, bus.pend}, 8'h01);
        check_val("lat_irqout_k2", {7'h0, bus.irq_out}, 8'h00);
        step(1);
        check_val("lat_irqout_k3", {7'h0, bus.irq_out}, 8'h01);
        do_ack(2'd0);
        check_val("ack0_in_svc", {7'h0, bus.in_svc}, 8'h01);
        check_val("ack0_pend",   {4'h0, bus.pend}, 8'h00);
        do_eoi();
        step(4);
        check_val("level_no_repend", {4'h0, bus.pend}, 8'h00);
        check_val("level_irq_out",   {7'h0, bus.irq_out}, 8'h00);

        // Handshake with simultaneous edges on lines 3 and 1
        bus.irq = 4'b1011;
        step(4);
        check_val("hs_pend",    {4'h0, bus.pend}, 8'h0a);
        check_val("hs_irq_out", {7'h0, bus.irq_out}, 8'h01);
        do_ack(2'd3);
        check_val("hs_ack_pend",   {4'h0, bus.pend}, 8'h02);
        check_val("hs_ack_in_svc", {7'h0, bus.in_svc}, 8'h01);
        check_val("hs_ack_svc_id", {6'h0, bus.svc_id}, 8'h03);
        check_val("hs_ack_irqout", {7'h0, bus.irq_out}, 8'h00);
        do_eoi();
        check_val("hs_eoi_in_svc", {7'h0, bus.in_svc}, 8'h00);
        check_val("hs_eoi_irqout", {7'h0, bus.irq_out}, 8'h00);
        check_val("hs_eoi_svc_id", {6'h0, bus.svc_id}, 8'h03);
        step(1);
        check_val("hs_reeval_irqout", {7'h0, bus.irq_out}, 8'h01);
        do_eoi();
        check_val("eoi_active_ignored", {7'h0, bus.irq_out}, 8'h01);

        // Bad ack in ACTIVE, then clear line 1
        do_ack(2'd0);
        check_val("bad_ack_pend",   {4'h0, bus.pend}, 8'h02);
        check_val("bad_ack_irqout", {7'h0, bus.irq_out}, 8'h01);
        check_val("bad_ack_in_svc", {7'h0, bus.in_svc}, 8'h00);
        do_ack(2'd1);
        check_val("ack1_svc_id", {6'h0, bus.svc_id}, 8'h01);
        do_eoi();
        bus.irq = 4'b0000;
        step(3);
        do_ack(2'd0);
        check_val("idle_ack_in_svc", {7'h0, bus.in_svc}, 8'h00);
        check_val("idle_ack_svc_id", {6'h0, bus.svc_id}, 8'h01);

        // Overflow: two pulses on line 1 before any ack
        pulse_irq(1);
        pulse_irq(1);
        step(2);
        check_val("ovf_set",  {4'h0, bus.ovf}, 8'h02);
        check_val("ovf_pend", {4'h0, bus.pend}, 8'h02);
        bus.clr_ovf = 1'b1;
        step(1);
        bus.clr_ovf = 1'b0;
        check_val("ovf_clr", {4'h0, bus.ovf}, 8'h00);
        // Ack lands in the same cycle the new edge sets line 1
        bus.irq[1] = 1'b1;
        step(2);
        do_ack(2'd1);
        check_val("ack_edge_pend",   {4'h0, bus.pend}, 8'h02);
        check_val("ack_edge_ovf",    {4'h0, bus.ovf}, 8'h00);
        check_val("ack_edge_in_svc", {7'h0, bus.in_svc}, 8'h01);
        bus.irq[1] = 1'b0;
        do_eoi();
        step(2);
        do_ack(2'd1);
        do_eoi();
        check_val("cleared_pend", {4'h0, bus.pend}, 8'h00);

        // Mask hides a pending line and drops the FSM back to IDLE
        bus.irq[3] = 1'b0;
        step(1);
        bus.irq[3] = 1'b1;
        step(4);
        check_val("mask_pre_pend",   {4'h0, bus.pend}, 8'h08);
        check_val("mask_pre_irqout", {7'h0, bus.irq_out}, 8'h01);
        bus.mask = 4'b1000;
        step(1);
        check_val("mask_pend",   {4'h0, bus.pend}, 8'h00);
        check_val("mask_irqout", {7'h0, bus.irq_out}, 8'h00);
        bus.mask = 4'b0000;
        step(1);
        check_val("unmask_pend",   {4'h0, bus.pend}, 8'h08);
        check_val("unmask_irqout", {7'h0, bus.irq_out}, 8'h01);

        // Reset mid-service with pending=0110
        do_ack(2'd3);
        bus.irq = 4'b1110;
        step(4);
        check_val("svc_pend",   {4'h0, bus.pend}, 8'h06);
        check_val("svc_in_svc", {7'h0, bus.in_svc}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_pend",   {4'h0, bus.pend}, 8'h00);
        check_val("arst_in_svc", {7'h0, bus.in_svc}, 8'h00);
        check_val("arst_irqout", {7'h0, bus.irq_out}, 8'h00);
        check_val("arst_svc_id", {6'h0, bus.svc_id}, 8'h00);
        check_val("arst_ovf",    {4'h0, bus.ovf}, 8'h00);
        bus.irq = 4'b1111;
        step(1);
        rst_n = 1'b1;
        step(8);
        check_val("post_rst_pend",   {4'h0, bus.pend}, 8'h00);
        check_val("post_rst_irqout", {7'h0, bus.irq_out}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
